// File: rtl/cam_init_sequencer.sv
// Power-up sequencer for NUM_CH camera channels: timed sensor/bridge reset release,
// then per-channel I2C controller release with config-done timeout and bounded retry.
module cam_init_sequencer #(
    parameter int NUM_CH    = 2,
    parameter int T_SENSOR  = 8388608,
    parameter int T_BRIDGE  = 65536,
    parameter int T_I2C     = 1024,
    parameter int T_TIMEOUT = 16777216,
    parameter int MAX_RETRY = 3,
    parameter int HB_BIT    = 28
) (
    input  logic                  clk_i,
    input  logic                  rst,
    input  logic [NUM_CH-1:0]     cfg_done,
    output logic                  sensor_rst_n,
    output logic                  bridge_rst_n,
    output logic [NUM_CH-1:0]     cfg_rst_n,
    output logic [NUM_CH-1:0]     ch_ok,
    output logic [NUM_CH-1:0]     ch_fail,
    output logic [4*NUM_CH-1:0]   retry_cnt,
    output logic                  init_done,
    output logic                  all_ok,
    output logic                  heartbeat
);

    localparam int T_PWR = T_SENSOR + T_BRIDGE;
    localparam int GW    = $clog2(T_PWR + 1);
    localparam int HW    = (T_I2C > 1) ? $clog2(T_I2C) : 1;
    localparam int TW    = (T_TIMEOUT > 1) ? $clog2(T_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_WAIT_PWR,
        S_HOLD,
        S_CFG,
        S_OK,
        S_FAIL
    } ch_state_t;

    logic [GW-1:0]        r_gcnt;
    logic                 r_sensor_rst_n;
    logic                 r_bridge_rst_n;
    logic [HB_BIT:0]      r_hb;
    ch_state_t            r_state [NUM_CH];
    logic [HW-1:0]        r_hcnt  [NUM_CH];
    logic [TW-1:0]        r_tcnt  [NUM_CH];
    logic [NUM_CH-1:0]    r_cfg_rst_n;
    logic [NUM_CH-1:0]    r_ch_ok;
    logic [NUM_CH-1:0]    r_ch_fail;
    logic [4*NUM_CH-1:0]  r_retry;
    logic                 r_init_done;
    logic                 r_all_ok;

    logic [GW-1:0]        w_gcnt_next;
    logic                 w_sensor_next;
    logic                 w_bridge_next;
    logic                 w_all_term;

    // Global counter saturates once the bridge release point is reached.
    assign w_gcnt_next   = (r_gcnt == GW'(T_PWR)) ? r_gcnt : r_gcnt + 1'b1;
    assign w_sensor_next = (w_gcnt_next >= GW'(T_SENSOR));
    assign w_bridge_next = (w_gcnt_next == GW'(T_PWR));
    assign w_all_term    = &(r_ch_ok | r_ch_fail);

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            r_gcnt         <= '0;
            r_sensor_rst_n <= 1'b0;
            r_bridge_rst_n <= 1'b0;
            r_hb           <= '0;
            r_init_done    <= 1'b0;
            r_all_ok       <= 1'b0;
        end else begin
            r_gcnt         <= w_gcnt_next;
            r_sensor_rst_n <= r_sensor_rst_n | w_sensor_next;
            r_bridge_rst_n <= r_bridge_rst_n | w_bridge_next;
            r_hb           <= r_hb + 1'b1;
            // Aggregates look at registered channel status, hence one edge of lag.
            r_init_done    <= w_all_term & r_bridge_rst_n;
            r_all_ok       <= w_all_term & r_bridge_rst_n & (&r_ch_ok);
        end
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i] <= S_WAIT_PWR;
                r_hcnt[i]  <= '0;
                r_tcnt[i]  <= '0;
            end
            r_cfg_rst_n <= '0;
            r_ch_ok     <= '0;
            r_ch_fail   <= '0;
            r_retry     <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                case (r_state[i])
                    S_WAIT_PWR: begin
                        r_cfg_rst_n[i] <= 1'b0;
                        if (w_sensor_next) begin
                            r_state[i] <= S_HOLD;
                            r_hcnt[i]  <= '0;
                        end
                    end
                    S_HOLD: begin
                        r_cfg_rst_n[i] <= 1'b0;
                        if (r_hcnt[i] == HW'(T_I2C - 1)) begin
                            r_state[i]     <= S_CFG;
                            r_cfg_rst_n[i] <= 1'b1;
                            r_tcnt[i]      <= '0;
                        end else begin
                            r_hcnt[i] <= r_hcnt[i] + 1'b1;
                        end
                    end
                    S_CFG: begin
                        // A done seen on the timeout edge still counts as success.
                        if (cfg_done[i]) begin
                            r_state[i] <= S_OK;
                            r_ch_ok[i] <= 1'b1;
                        end else if (r_tcnt[i] == TW'(T_TIMEOUT - 1)) begin
                            r_cfg_rst_n[i] <= 1'b0;
                            if (r_retry[4*i +: 4] < 4'(MAX_RETRY)) begin
                                r_retry[4*i +: 4] <= r_retry[4*i +: 4] + 4'd1;
                                r_state[i]        <= S_HOLD;
                                r_hcnt[i]         <= '0;
                            end else begin
                                r_state[i]   <= S_FAIL;
                                r_ch_fail[i] <= 1'b1;
                            end
                        end else begin
                            r_tcnt[i] <= r_tcnt[i] + 1'b1;
                        end
                    end
                    S_OK: begin
                        r_cfg_rst_n[i] <= 1'b1;
                    end
                    S_FAIL: begin
                        r_cfg_rst_n[i] <= 1'b0;
                    end
                    default: begin
                        r_state[i]     <= S_FAIL;
                        r_cfg_rst_n[i] <= 1'b0;
                        r_ch_fail[i]   <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign sensor_rst_n = r_sensor_rst_n;
    assign bridge_rst_n = r_bridge_rst_n;
    assign cfg_rst_n    = r_cfg_rst_n;
    assign ch_ok        = r_ch_ok;
    assign ch_fail      = r_ch_fail;
    assign retry_cnt    = r_retry;
    assign init_done    = r_init_done;
    assign all_ok       = r_all_ok;
    assign heartbeat    = r_hb[HB_BIT];

endmodule

// File: tb/tb_cam_init_sequencer.sv
// Directed bench for cam_init_sequencer with small timing parameters and HB_BIT=3.
module tb_cam_init_sequencer;

    logic       clk_i;
    logic       rst;
    logic [1:0] cfg_done;
    logic       sensor_rst_n;
    logic       bridge_rst_n;
    logic [1:0] cfg_rst_n;
    logic [1:0] ch_ok;
    logic [1:0] ch_fail;
    logic [7:0] retry_cnt;
    logic       init_done;
    logic       all_ok;
    logic       heartbeat;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;

    cam_init_sequencer #(
        .NUM_CH(2), .T_SENSOR(16), .T_BRIDGE(8), .T_I2C(4),
        .T_TIMEOUT(20), .MAX_RETRY(2), .HB_BIT(3)
    ) dut (
        .clk_i(clk_i), .rst(rst), .cfg_done(cfg_done),
        .sensor_rst_n(sensor_rst_n), .bridge_rst_n(bridge_rst_n),
        .cfg_rst_n(cfg_rst_n), .ch_ok(ch_ok), .ch_fail(ch_fail),
        .retry_cnt(retry_cnt), .init_done(init_done), .all_ok(all_ok),
        .heartbeat(heartbeat)
    );

    // Clock and reset
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i or posedge rst) begin
        if (rst) edge_n <= 0;
        else     edge_n <= edge_n + 1;
    end

    // Advance to the negedge following edge k.
    task automatic wait_edge(input int k);
        int guard;
        guard = 0;
        while (edge_n < k) begin
            @(negedge clk_i);
            guard++;
            if (guard > 1000) begin
                n_checks++; n_fail++;
                $display("FAIL wait_edge_%0d: timed out at edge %0d, required edge %0d", k, edge_n, k);
                return;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst = 1'b1;
        cfg_done = 2'b00;
        repeat (2) @(negedge clk_i);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        rst = 1'b1;
        cfg_done = 2'b00;
        repeat (2) @(negedge clk_i);
        n_checks++;
        if ({sensor_rst_n, bridge_rst_n, cfg_rst_n, ch_ok, ch_fail, retry_cnt, init_done, all_ok, heartbeat} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required all zero",
                     {sensor_rst_n, bridge_rst_n, cfg_rst_n, ch_ok, ch_fail, retry_cnt, init_done, all_ok, heartbeat});
        end
        rst = 1'b0;
    endtask

    task automatic test_power_seq();
        do_reset();
        wait_edge(7);
        n_checks++; if (heartbeat !== 1'b0) begin n_fail++; $display("FAIL hb_7: got %b required 0", heartbeat); end
        wait_edge(8);
        n_checks++; if (heartbeat !== 1'b1) begin n_fail++; $display("FAIL hb_8: got %b required 1", heartbeat); end
        wait_edge(15);
        n_checks++; if (sensor_rst_n !== 1'b0) begin n_fail++; $display("FAIL sensor_15: got %b required 0", sensor_rst_n); end
        n_checks++; if (heartbeat !== 1'b1) begin n_fail++; $display("FAIL hb_15: got %b required 1", heartbeat); end
        wait_edge(16);
        n_checks++; if (sensor_rst_n !== 1'b1) begin n_fail++; $display("FAIL sensor_16: got %b required 1", sensor_rst_n); end
        n_checks++; if (heartbeat !== 1'b0) begin n_fail++; $display("FAIL hb_16: got %b required 0", heartbeat); end
        wait_edge(19);
        n_checks++; if (cfg_rst_n !== 2'b00) begin n_fail++; $display("FAIL cfg_rst_19: got %b required 00", cfg_rst_n); end
        wait_edge(20);
        n_checks++; if (cfg_rst_n !== 2'b11) begin n_fail++; $display("FAIL cfg_rst_20: got %b required 11", cfg_rst_n); end
        wait_edge(23);
        n_checks++; if (bridge_rst_n !== 1'b0) begin n_fail++; $display("FAIL bridge_23: got %b required 0", bridge_rst_n); end
        wait_edge(24);
        n_checks++; if (bridge_rst_n !== 1'b1) begin n_fail++; $display("FAIL bridge_24: got %b required 1", bridge_rst_n); end
    endtask

    task automatic test_ch_ok();
        do_reset();
        wait_edge(29);
        n_checks++; if (ch_ok !== 2'b00) begin n_fail++; $display("FAIL ok_29: got %b required 00", ch_ok); end
        cfg_done[0] = 1'b1;
        wait_edge(30);
        n_checks++; if (ch_ok !== 2'b01) begin n_fail++; $display("FAIL ok_30: got %b required 01", ch_ok); end
        wait_edge(45);
        n_checks++; if (retry_cnt !== 8'h10) begin n_fail++; $display("FAIL retry_45: got %h required 10", retry_cnt); end
        n_checks++; if (cfg_rst_n[0] !== 1'b1) begin n_fail++; $display("FAIL ok_cfg_rst_45: got %b required 1", cfg_rst_n[0]); end
        cfg_done[0] = 1'b0;
        wait_edge(50);
        n_checks++; if (ch_ok[0] !== 1'b1 || cfg_rst_n[0] !== 1'b1) begin
            n_fail++; $display("FAIL ok_sticky_50: got ok=%b rst_n=%b required 1 1", ch_ok[0], cfg_rst_n[0]);
        end
    endtask

    task automatic test_retry_fail();
        do_reset();
        wait_edge(39);
        n_checks++; if (cfg_rst_n[1] !== 1'b1) begin n_fail++; $display("FAIL retry_39: got %b required 1", cfg_rst_n[1]); end
        wait_edge(40);
        n_checks++; if (cfg_rst_n[1] !== 1'b0 || retry_cnt[7:4] !== 4'd1) begin
            n_fail++; $display("FAIL retry_40: got rst_n=%b cnt=%0d required 0 1", cfg_rst_n[1], retry_cnt[7:4]);
        end
        wait_edge(43);
        n_checks++; if (cfg_rst_n[1] !== 1'b0) begin n_fail++; $display("FAIL retry_43: got %b required 0", cfg_rst_n[1]); end
        wait_edge(44);
        n_checks++; if (cfg_rst_n[1] !== 1'b1) begin n_fail++; $display("FAIL retry_44: got %b required 1", cfg_rst_n[1]); end
        wait_edge(64);
        n_checks++; if (cfg_rst_n[1] !== 1'b0 || retry_cnt[7:4] !== 4'd2) begin
            n_fail++; $display("FAIL retry_64: got rst_n=%b cnt=%0d required 0 2", cfg_rst_n[1], retry_cnt[7:4]);
        end
        wait_edge(68);
        n_checks++; if (cfg_rst_n[1] !== 1'b1) begin n_fail++; $display("FAIL retry_68: got %b required 1", cfg_rst_n[1]); end
        wait_edge(87);
        n_checks++; if (ch_fail !== 2'b00 || cfg_rst_n[1] !== 1'b1) begin
            n_fail++; $display("FAIL fail_87: got fail=%b rst_n=%b required 00 1", ch_fail, cfg_rst_n[1]);
        end
        wait_edge(88);
        n_checks++; if (ch_fail !== 2'b11 || cfg_rst_n !== 2'b00 || init_done !== 1'b0) begin
            n_fail++; $display("FAIL fail_88: got fail=%b rst_n=%b done=%b required 11 00 0", ch_fail, cfg_rst_n, init_done);
        end
        wait_edge(89);
        n_checks++; if (init_done !== 1'b1 || all_ok !== 1'b0) begin
            n_fail++; $display("FAIL done_89: got done=%b all_ok=%b required 1 0", init_done, all_ok);
        end
        wait_edge(100);
        n_checks++; if (cfg_rst_n !== 2'b00 || retry_cnt !== 8'h22) begin
            n_fail++; $display("FAIL fail_hold_100: got rst_n=%b cnt=%h required 00 22", cfg_rst_n, retry_cnt);
        end
    endtask

    task automatic test_done_on_timeout_edge();
        do_reset();
        wait_edge(39);
        cfg_done[0] = 1'b1;
        wait_edge(40);
        n_checks++; if (ch_ok[0] !== 1'b1 || cfg_rst_n[0] !== 1'b1 || retry_cnt[3:0] !== 4'd0) begin
            n_fail++; $display("FAIL tie_40: got ok=%b rst_n=%b cnt=%0d required 1 1 0", ch_ok[0], cfg_rst_n[0], retry_cnt[3:0]);
        end
        wait_edge(44);
        n_checks++; if (cfg_rst_n[0] !== 1'b1) begin n_fail++; $display("FAIL tie_44: got %b required 1", cfg_rst_n[0]); end
    endtask

    task automatic test_early_ok();
        do_reset();
        wait_edge(20);
        cfg_done = 2'b11;
        wait_edge(21);
        n_checks++; if (ch_ok !== 2'b11) begin n_fail++; $display("FAIL early_ok_21: got %b required 11", ch_ok); end
        wait_edge(24);
        n_checks++; if (init_done !== 1'b0 || all_ok !== 1'b0) begin
            n_fail++; $display("FAIL early_done_24: got done=%b all_ok=%b required 0 0", init_done, all_ok);
        end
        wait_edge(25);
        n_checks++; if (init_done !== 1'b1 || all_ok !== 1'b1) begin
            n_fail++; $display("FAIL early_done_25: got done=%b all_ok=%b required 1 1", init_done, all_ok);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        wait_edge(50);
        n_checks++; if (sensor_rst_n !== 1'b1 || bridge_rst_n !== 1'b1) begin
            n_fail++; $display("FAIL pre_rst_50: got sensor=%b bridge=%b required 1 1", sensor_rst_n, bridge_rst_n);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({sensor_rst_n, bridge_rst_n, cfg_rst_n, ch_ok, ch_fail, retry_cnt, init_done, all_ok, heartbeat} !== 19'd0) begin
            n_fail++;
            $display("FAIL async_rst: got %b required all zero",
                     {sensor_rst_n, bridge_rst_n, cfg_rst_n, ch_ok, ch_fail, retry_cnt, init_done, all_ok, heartbeat});
        end
        rst = 1'b0;
        wait_edge(15);
        n_checks++; if (sensor_rst_n !== 1'b0) begin n_fail++; $display("FAIL restart_15: got %b required 0", sensor_rst_n); end
        wait_edge(16);
        n_checks++; if (sensor_rst_n !== 1'b1) begin n_fail++; $display("FAIL restart_16: got %b required 1", sensor_rst_n); end
    endtask

    initial begin
        rst = 1'b1;
        cfg_done = 2'b00;
        test_reset();
        test_power_seq();
        test_ch_ok();
        test_retry_fail();
        test_done_on_timeout_edge();
        test_early_ok();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
